// File: rtl/vul16_pkg.sv
// Shared widths and types for the VUL16 core.
package vul16_pkg;

  localparam int INST_W = 16;
  localparam int ADDR_W = 16;
  localparam int MEM_READ_LATENCY = 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, inst} pairs; entry 0 is the head.
module fetch_queue
  import vul16_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t entries_reg  [DEPTH];
  fetch_entry_t entries_next [DEPTH];
  logic [1:0]   count_reg;
  logic [1:0]   count_next;
  logic         do_pop;
  logic [1:0]   wr_idx;

  assign do_pop = pop && (count_reg != 2'd0);
  // A push lands behind whatever survives this cycle's pop.
  assign wr_idx = count_reg - {1'b0, do_pop};

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_next[i] = entries_reg[i];
    end
    count_next = count_reg;
    if (flush) begin
      count_next = 2'd0;
    end else begin
      if (do_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          entries_next[i] = entries_reg[i+1];
        end
      end
      if (push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wr_idx == 2'(i)) begin
            entries_next[i] = push_data;
          end
        end
      end
      count_next = count_reg + {1'b0, push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_reg[i] <= '0;
      end
      count_reg <= 2'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_reg[i] <= entries_next[i];
      end
      count_reg <= count_next;
    end
  end

  assign head  = entries_reg[0];
  assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// VUL16 instruction fetch: PC generation, one outstanding memory read,
// a 2-entry output queue to decode and redirect handling.
module fetch_unit
  import vul16_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [INST_W-1:0] inst_in,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc
);

  localparam logic [ADDR_W-1:0] START_PC = RESET_PC & 16'hFFFE;
  localparam logic [2:0]        DEPTH_L  = 3'(QUEUE_DEPTH);

  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic              inflight_valid_reg, inflight_valid_next;
  logic [ADDR_W-1:0] inflight_pc_reg, inflight_pc_next;

  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        occupancy;
  logic [1:0]        queue_count;
  logic [ADDR_W-1:0] redirect_target;
  fetch_entry_t      push_data;
  fetch_entry_t      head;

  assign out_valid       = (queue_count != 2'd0);
  assign pop             = out_valid && out_ready;
  assign redirect_target = redirect_pc & 16'hFFFE;

  // Count the in-flight read as already occupying a slot so its return never overflows.
  assign occupancy = {1'b0, queue_count} + {2'b00, inflight_valid_reg} - {2'b00, pop};
  assign issue     = !redirect_valid && (occupancy < DEPTH_L);
  assign push      = inflight_valid_reg && !redirect_valid;
  assign push_data = '{pc: inflight_pc_reg, inst: inst_in};

  always_comb begin
    fetch_pc_next       = fetch_pc_reg;
    inflight_pc_next    = inflight_pc_reg;
    inflight_valid_next = issue;
    if (redirect_valid) begin
      fetch_pc_next = redirect_target;
    end else if (issue) begin
      inflight_pc_next = fetch_pc_reg;
      fetch_pc_next    = fetch_pc_reg + 16'd2;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_reg       <= START_PC;
      inflight_valid_reg <= 1'b0;
      inflight_pc_reg    <= '0;
    end else begin
      fetch_pc_reg       <= fetch_pc_next;
      inflight_valid_reg <= inflight_valid_next;
      inflight_pc_reg    <= inflight_pc_next;
    end
  end

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .flush    (redirect_valid),
    .head     (head),
    .count    (queue_count)
  );

  assign inst_addr = fetch_pc_reg;
  assign out_inst  = head.inst;
  assign out_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a 1-cycle memory model returns addr ^ 16'hA5A5.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic [15:0] inst_addr, inst_in;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [15:0] out_inst, out_pc;

  logic [15:0] w_inst_addr, w_inst_in;
  logic        w_redirect_valid;
  logic [15:0] w_redirect_pc;
  logic        w_out_valid, w_out_ready;
  logic [15:0] w_out_inst, w_out_pc;

  int          checks_total;
  int          checks_passed;
  logic [15:0] exp_q[$];
  logic [15:0] w_exp_q[$];
  logic [15:0] mon_exp, w_mon_exp;

  fetch_unit #(.RESET_PC(16'h0000), .QUEUE_DEPTH(2)) dut (
    .clock(clock), .reset(reset), .inst_addr(inst_addr), .inst_in(inst_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc)
  );

  fetch_unit #(.RESET_PC(16'hFFFC), .QUEUE_DEPTH(2)) dut_w (
    .clock(clock), .reset(reset), .inst_addr(w_inst_addr), .inst_in(w_inst_in),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_inst(w_out_inst), .out_pc(w_out_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    inst_in   <= inst_addr ^ 16'hA5A5;
    w_inst_in <= w_inst_addr ^ 16'hA5A5;
  end

  // Handshakes in a reset or redirect cycle are dropped by decode, so they are not scored.
  always @(negedge clock) begin
    if (!reset && !redirect_valid && out_valid && out_ready) begin
      checks_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_extra: got pc=%h inst=%h, required no transaction", out_pc, out_inst);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_pc !== mon_exp || out_inst !== (mon_exp ^ 16'hA5A5))
          $display("FAIL sb_txn: got pc=%h inst=%h, required pc=%h inst=%h",
                   out_pc, out_inst, mon_exp, mon_exp ^ 16'hA5A5);
        else begin
          checks_passed++;
          $display("txn pc=%h inst=%h", out_pc, out_inst);
        end
      end
    end
    if (!reset && w_out_valid && w_out_ready) begin
      checks_total++;
      if (w_exp_q.size() == 0) begin
        $display("FAIL sb_wrap_extra: got pc=%h, required no transaction", w_out_pc);
      end else begin
        w_mon_exp = w_exp_q.pop_front();
        if (w_out_pc !== w_mon_exp || w_out_inst !== (w_mon_exp ^ 16'hA5A5))
          $display("FAIL sb_wrap_txn: got pc=%h inst=%h, required pc=%h inst=%h",
                   w_out_pc, w_out_inst, w_mon_exp, w_mon_exp ^ 16'hA5A5);
        else begin
          checks_passed++;
          $display("txn wrap pc=%h inst=%h", w_out_pc, w_out_inst);
        end
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", out_valid); else checks_passed++;
    checks_total++; if (out_pc !== 16'h0000) $display("FAIL reset_pc: got %h required 0000", out_pc); else checks_passed++;
    checks_total++; if (out_inst !== 16'h0000) $display("FAIL reset_inst: got %h required 0000", out_inst); else checks_passed++;
    checks_total++; if (inst_addr !== 16'h0000) $display("FAIL reset_addr: got %h required 0000", inst_addr); else checks_passed++;
    checks_total++; if (w_inst_addr !== 16'hFFFC) $display("FAIL reset_wrap_addr: got %h required fffc", w_inst_addr); else checks_passed++;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) exp_q.push_back(16'(2 * i));
    @(posedge clock); #1; reset = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    checks_total++; if (out_valid !== 1'b0 || inst_addr !== 16'h0000) $display("FAIL stream_c0: got valid=%b addr=%h required 0/0000", out_valid, inst_addr); else checks_passed++;
    @(negedge clock);
    checks_total++; if (out_valid !== 1'b0 || inst_addr !== 16'h0002) $display("FAIL stream_c1: got valid=%b addr=%h required 0/0002", out_valid, inst_addr); else checks_passed++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checks_total++; if (out_valid !== 1'b1) $display("FAIL stream_bubble: got valid=%b required 1 at beat %0d", out_valid, i); else checks_passed++;
    end
    @(posedge clock); #1; out_ready = 1'b0;
    checks_total++; if (exp_q.size() != 0) $display("FAIL stream_drain: got %0d left required 0", exp_q.size()); else checks_passed++;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks_total++; if (out_valid !== 1'b1 || out_pc !== 16'h0010 || inst_addr !== 16'h0014)
        $display("FAIL bp_hold: got valid=%b pc=%h addr=%h required 1/0010/0014", out_valid, out_pc, inst_addr); else checks_passed++;
    end
    checks_total++; if (dut.queue_count !== 2'd2) $display("FAIL bp_count: got %0d required 2", dut.queue_count); else checks_passed++;
    for (int i = 0; i < 8; i++) exp_q.push_back(16'(16 + 2 * i));
    @(posedge clock); #1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checks_total++; if (out_valid !== 1'b1) $display("FAIL bp_gap: got valid=%b required 1 at beat %0d", out_valid, i); else checks_passed++;
    end
    @(posedge clock); #1; out_ready = 1'b0;
    checks_total++; if (exp_q.size() != 0) $display("FAIL bp_drain: got %0d left required 0", exp_q.size()); else checks_passed++;
  endtask

  task automatic test_redirect();
    repeat (3) @(negedge clock);
    checks_total++; if (dut.queue_count !== 2'd2) $display("FAIL redir_full: got %0d required 2", dut.queue_count); else checks_passed++;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(16'(16'h0122 + 2 * i));
    @(posedge clock); #1; redirect_valid = 1'b1; redirect_pc = 16'h0123; out_ready = 1'b1;
    @(negedge clock);
    @(posedge clock); #1; redirect_valid = 1'b0;
    @(negedge clock);
    checks_total++; if (out_valid !== 1'b0 || inst_addr !== 16'h0122) $display("FAIL redir_r1: got valid=%b addr=%h required 0/0122", out_valid, inst_addr); else checks_passed++;
    @(negedge clock);
    checks_total++; if (out_valid !== 1'b0) $display("FAIL redir_r2: got valid=%b required 0", out_valid); else checks_passed++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks_total++; if (out_valid !== 1'b1) $display("FAIL redir_stream: got valid=%b required 1 at beat %0d", out_valid, i); else checks_passed++;
    end
    @(posedge clock); #1; out_ready = 1'b0;
    checks_total++; if (exp_q.size() != 0) $display("FAIL redir_drain: got %0d left required 0", exp_q.size()); else checks_passed++;
  endtask

  task automatic test_redirect_return();
    repeat (2) @(negedge clock);
    exp_q.push_back(16'h012A);
    @(posedge clock); #1; out_ready = 1'b1;
    @(negedge clock);
    @(posedge clock); #1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(16'(16'h4000 + 2 * i));
    redirect_valid = 1'b1; redirect_pc = 16'h4001;
    @(negedge clock);
    checks_total++; if (dut.inflight_valid_reg !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL rr_setup: got inflight=%b valid=%b required 1/1", dut.inflight_valid_reg, out_valid); else checks_passed++;
    @(posedge clock); #1; redirect_valid = 1'b0;
    @(negedge clock);
    checks_total++; if (out_valid !== 1'b0 || inst_addr !== 16'h4000) $display("FAIL rr_r1: got valid=%b addr=%h required 0/4000", out_valid, inst_addr); else checks_passed++;
    @(negedge clock);
    checks_total++; if (out_valid !== 1'b0) $display("FAIL rr_r2: got valid=%b required 0", out_valid); else checks_passed++;
    @(negedge clock);
    checks_total++; if (out_valid !== 1'b1 || out_pc !== 16'h4000) $display("FAIL rr_r3: got valid=%b pc=%h required 1/4000", out_valid, out_pc); else checks_passed++;
    repeat (3) @(negedge clock);
    @(posedge clock); #1; out_ready = 1'b0;
    checks_total++; if (exp_q.size() != 0) $display("FAIL rr_drain: got %0d left required 0", exp_q.size()); else checks_passed++;
  endtask

  task automatic test_wrap();
    @(posedge clock); #1; reset = 1'b1;
    repeat (2) @(posedge clock);
    #1; reset = 1'b0; w_out_ready = 1'b1;
    w_exp_q.push_back(16'hFFFC); w_exp_q.push_back(16'hFFFE);
    w_exp_q.push_back(16'h0000); w_exp_q.push_back(16'h0002);
    repeat (2) begin
      @(negedge clock);
      checks_total++; if (w_out_valid !== 1'b0) $display("FAIL wrap_early: got valid=%b required 0", w_out_valid); else checks_passed++;
    end
    repeat (4) @(negedge clock);
    @(posedge clock); #1; w_out_ready = 1'b0;
    checks_total++; if (w_exp_q.size() != 0) $display("FAIL wrap_drain: got %0d left required 0", w_exp_q.size()); else checks_passed++;
  endtask

  task automatic test_midrun_reset();
    exp_q.push_back(16'h0000);
    @(posedge clock); #1; out_ready = 1'b1;
    @(negedge clock);
    @(posedge clock); #1;
    exp_q.delete();
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0300;
    @(negedge clock);
    checks_total++; if (dut.inflight_valid_reg !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL mr_setup: got inflight=%b valid=%b required 1/1", dut.inflight_valid_reg, out_valid); else checks_passed++;
    @(posedge clock); #1; reset = 1'b0; redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(16'(2 * i));
    @(negedge clock);
    checks_total++; if (out_valid !== 1'b0 || inst_addr !== 16'h0000 || out_pc !== 16'h0000 || out_inst !== 16'h0000)
      $display("FAIL mr_c0: got valid=%b addr=%h pc=%h inst=%h required 0/0000/0000/0000", out_valid, inst_addr, out_pc, out_inst); else checks_passed++;
    @(negedge clock);
    checks_total++; if (out_valid !== 1'b0) $display("FAIL mr_c1: got valid=%b required 0", out_valid); else checks_passed++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks_total++; if (out_valid !== 1'b1) $display("FAIL mr_stream: got valid=%b required 1 at beat %0d", out_valid, i); else checks_passed++;
    end
    @(posedge clock); #1; out_ready = 1'b0;
    checks_total++; if (exp_q.size() != 0) $display("FAIL mr_drain: got %0d left required 0", exp_q.size()); else checks_passed++;
  endtask

  initial begin
    checks_total     = 0;
    checks_passed    = 0;
    reset            = 1'b1;
    out_ready        = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = 16'h0000;
    w_out_ready      = 1'b0;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = 16'h0000;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_return();
    test_wrap();
    test_midrun_reset();
    repeat (2) @(posedge clock);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the VUL16 core. It drives the instruction-port address of the dual-port BSRAM memory block and consumes its 16-bit instruction word. It buffers fetched instructions, each tagged with its PC, in a 2-entry queue. It presents them to decode through a valid/ready handshake and accepts PC redirects from execute (branches/jumps).

## Interface

Parameters:
- RESET_PC, 16'h0000, first fetch address after reset; bit 0 ignored.
- QUEUE_DEPTH, 2, output queue entries; only 2 is supported.

Ports:
- clock  in  1  single clock for the block.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of `clock`.
- inst_addr  out  16  byte address to memory instruction port; bit 0 always 0.
- inst_in  in  16  instruction word from memory; valid exactly 1 cycle after `inst_addr` is presented.
- redirect_valid  in  1  one-cycle pulse requesting a PC change.
- redirect_pc  in  16  target byte address; bit 0 forced to 0.
- out_valid  out  1  queue head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_inst  out  16  head instruction.
- out_pc  out  16  byte address of the head instruction.

## Operation

- State registers:
  - `fetch_pc`: next address to issue.
  - `inflight_valid` and `inflight_pc`: the one outstanding read.
  - Queue: 2 entries of {pc, inst}, plus `count` (0..2).
- `inst_addr` = `fetch_pc`, driven directly from the register.
- Issue condition: `count + inflight_valid - pop < 2`, where pop = out_valid & out_ready, and no redirect this cycle.
  - On issue: `inflight_valid` <= 1, `inflight_pc` <= `fetch_pc`, `fetch_pc` <= `fetch_pc` + 2.
  - The add wraps modulo 2^16, so 0xFFFE is followed by 0x0000.
- Return: when `inflight_valid` = 1 and there is no redirect, push {`inflight_pc`, `inst_in`} into the queue.
  - The issue rule guarantees the push never overflows.
- Push and pop in the same cycle are legal and leave `count` unchanged.
- Redirect (highest priority):
  - Queue is flushed (`count` <= 0).
  - `inflight_valid` <= 0, and the returning word is discarded.
  - `fetch_pc` <= {redirect_pc[15:1], 1'b0}.
  - No issue that cycle.
  - A pop in the same cycle is still considered taken by decode. Decode must ignore it, since the redirect originates downstream.
- out_valid = (`count` != 0). `out_inst` and `out_pc` come from the queue head, which is registered state.
- The fetch address is not range-checked. Memory ignores bit 0, and only addresses below 0x8000 are backed.

## Timing

- Reset values:
  - `fetch_pc` = RESET_PC & 16'hFFFE.
  - `inflight_valid` = 0, `count` = 0.
  - `out_valid` = 0; `out_inst` = 0 and `out_pc` = 0.
  - `inst_addr` = RESET_PC & 16'hFFFE.
- After reset deasserts at edge E0:
  - First issue in cycle 0.
  - Data arrives in cycle 1 and is pushed at the end of cycle 1.
  - `out_valid` = 1 in cycle 2.
- Steady state with out_ready held at 1: one instruction per cycle, no bubbles.
- Redirect in cycle R:
  - Issue of the target in R+1.
  - `out_valid` for the target in R+3.
  - `out_valid` = 0 in R+1 and R+2.
- Back-pressure: with out_ready = 0 the queue fills to 2 and issue stops. Nothing already fetched is lost or duplicated.
- Reset mid-operation overrides everything in the same cycle, including redirect and push, and gives the reset values above.

## Structure

- Shared package `vul16_pkg`:
  - `INST_W` = 16 and `ADDR_W` = 16.
  - `MEM_READ_LATENCY` = 1.
  - `fetch_entry_t` struct {pc, inst}.
- Sub-module `fetch_queue`: 2-entry synchronous FIFO.
  - Ports: push, push_data, pop, flush, head, count.
  - Flush has priority over push.
- `fetch_unit` holds the PC, in-flight tracking and issue/redirect control.

## Test plan

- Stream from reset: memory model returns inst = addr ^ 16'hA5A5, out_ready = 1 → out_pc 0x0000, 0x0002, 0x0004… on consecutive cycles starting at cycle 2, each with the matching inst.
- Back-pressure: out_ready = 0 for 5 cycles then 1 → `count` saturates at 2, `inst_addr` is held, and the sequence resumes with no gap, duplicate or skip.
- Redirect: pulse redirect_valid with redirect_pc = 0x0123 while the queue is full → outputs invalid for 2 cycles, then out_pc = 0x0122. The stale in-flight word never appears.
- Redirect coinciding with return and pop: redirect on the cycle `inst_in` returns, with out_ready = 1 → returned word dropped; next out_pc = target.
- Wrap: RESET_PC = 16'hFFFC → out_pc sequence 0xFFFC, 0xFFFE, 0x0000.
- Mid-run reset: assert reset for 1 cycle while `count` = 2 and a read is in flight → next cycle `out_valid` = 0 and `inst_addr` = RESET_PC, and the stream restarts per the reset timing.
